// File: rtl/main_mem_responder.sv
// main_mem_responder
//
// Memory-side completer for the cache controller's block-transfer requests. Accepts one
// block read (refill, R_W=0) or block write (write-back, R_W=1) at a time. After a request
// is accepted it waits LATENCY cycles, then streams WPB words one per cycle from or into
// an internal 2^ADDR_W-word array. It closes every transaction with a one-cycle Done.
//
// Ports:
//   CLK       clock, rising edge
//   RST_N     asynchronous active-low reset (the array itself is not reset)
//   Req       request strobe, sampled only while idle
//   R_W       direction: 0 = read block, 1 = write block
//   Addr      word address; the low log2(WPB) bits select the word within the block
//   Wr_Data   write-beat data
//   Wr_Valid  write beat present; a low cycle stalls the write burst
//   Rd_Data   read-beat data, 0 outside a read burst
//   Rd_Valid  Rd_Data valid this cycle
//   PNDNG     transaction in progress (wait and burst states)
//   Done      one-cycle completion pulse
//
// Optional feature: define MAIN_MEM_CWF_EN for critical-word-first reads. Read bursts then
// start at the requested word offset and wrap within the block. Write bursts always start
// at word 0. With the macro undefined every burst starts at word 0 of the block.

module main_mem_responder #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned WPB     = 4,
   parameter int unsigned LATENCY = 3
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              Req,
   input  logic              R_W,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] Wr_Data,
   input  logic              Wr_Valid,
   output logic [DATA_W-1:0] Rd_Data,
   output logic              Rd_Valid,
   output logic              PNDNG,
   output logic              Done
);

   localparam int unsigned OW = $clog2(WPB);          // word-offset width
   localparam int unsigned LW = $clog2(LATENCY + 1);  // latency counter width
   localparam int unsigned BW = ADDR_W - OW;          // block-number width

   typedef enum logic [2:0] {StIdle, StWait, StRdBurst, StWrBurst, StDone} state_e;

   state_e          state_q, state_d;
   logic [OW-1:0]   beat_q, beat_d;
   logic [LW-1:0]   lat_q, lat_d;
   logic [BW-1:0]   blk_q, blk_d;
   logic            dir_q, dir_d;
   logic [OW-1:0]   word;
   logic            mem_we;

   logic [DATA_W-1:0] mem [2**ADDR_W];

`ifdef MAIN_MEM_CWF_EN
   logic [OW-1:0] off_q, off_d;

   // Offset + beat wraps modulo WPB through the OW-bit truncation.
   assign word = beat_q + off_q;
`else
   logic unused_offset;

   assign unused_offset = ^Addr[OW-1:0];
   assign word          = beat_q;
`endif

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      lat_d    = lat_q;
      blk_d    = blk_q;
      dir_d    = dir_q;
`ifdef MAIN_MEM_CWF_EN
      off_d    = off_q;
`endif
      mem_we   = 1'b0;
      Rd_Valid = 1'b0;
      PNDNG    = 1'b0;
      Done     = 1'b0;
      Rd_Data  = '0;

      unique case (state_q)
         StIdle: begin
            if (Req) begin
               blk_d   = Addr[ADDR_W-1:OW];
               dir_d   = R_W;
               beat_d  = '0;
               lat_d   = LW'(LATENCY - 1);
`ifdef MAIN_MEM_CWF_EN
               off_d   = R_W ? '0 : Addr[OW-1:0];
`endif
               state_d = StWait;
            end
         end
         StWait: begin
            PNDNG = 1'b1;
            if (lat_q == '0) begin
               state_d = dir_q ? StWrBurst : StRdBurst;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         StRdBurst: begin
            PNDNG    = 1'b1;
            Rd_Valid = 1'b1;
            Rd_Data  = mem[{blk_q, word}];
            beat_d   = beat_q + 1'b1;
            if (beat_q == OW'(WPB - 1)) begin
               state_d = StDone;
            end
         end
         StWrBurst: begin
            PNDNG = 1'b1;
            if (Wr_Valid) begin
               mem_we = 1'b1;
               beat_d = beat_q + 1'b1;
               if (beat_q == OW'(WPB - 1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            Done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         beat_q  <= '0;
         lat_q   <= '0;
         blk_q   <= '0;
         dir_q   <= 1'b0;
`ifdef MAIN_MEM_CWF_EN
         off_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         blk_q   <= blk_d;
         dir_q   <= dir_d;
`ifdef MAIN_MEM_CWF_EN
         off_q   <= off_d;
`endif
      end
   end

   // Write bursts always address from word 0 of the block, even with critical-word-first.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[{blk_q, beat_q}] <= Wr_Data;
      end
   end

endmodule
